// File: rtl/ro_gate_counter.sv
// Multi-channel ring-oscillator frequency meter: counts rising edges of one
// selected asynchronous tap over a programmable gate window of clk cycles.
module ro_gate_counter #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 12,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = $clog2(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] osc_in_i,
  input  logic [SEL_W-1:0]    chan_sel_i,
  input  logic [GATE_W-1:0]   gate_len_i,
  input  logic                start_i,
  input  logic                continuous_i,
  input  logic                shift_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                result_stb_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                overflow_o,
  output logic                sout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_DONE
  } state_e;

  localparam int                ARM_W      = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0]  ARM_LAST   = ARM_W'(SYNC_STAGES);
  localparam logic [GATE_W-1:0] TIMER_LAST = GATE_W'(1);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [ARM_W-1:0]       arm_q, arm_d;
  logic [GATE_W-1:0]      timer_q, timer_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic                   stb_q, stb_d;

  logic                   osc_sel;
  logic                   rising;
  logic [CNT_W-1:0]       edges_total;
  logic                   sat_total;
  logic                   win_end;

  // Only the latched channel is synchronised; the history flop follows the
  // last synchroniser stage so a rising edge is seen exactly once.
  always_comb begin
    osc_sel     = osc_in_i[sel_q];
    rising      = sync_q[SYNC_STAGES-1] & ~hist_q;
    edges_total = cnt_q;
    sat_total   = sat_q;
    if (rising) begin
      if (&cnt_q) begin
        sat_total = 1'b1;
      end else begin
        edges_total = cnt_q + 1'b1;
      end
    end
    win_end = (state_q == S_GATE) && (timer_q == TIMER_LAST);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    arm_d   = arm_q;
    timer_d = timer_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], osc_sel};
    hist_d  = sync_q[SYNC_STAGES-1];
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    stb_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_ARM;
          sel_d   = chan_sel_i;
          gate_d  = gate_len_i;
          arm_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          done_d  = 1'b0;
        end else if (shift_i) begin
          count_d = {count_q[CNT_W-2:0], 1'b0};
        end
      end

      S_ARM: begin
        arm_d = arm_q + 1'b1;
        if (arm_q == ARM_LAST) begin
          state_d = S_GATE;
          timer_d = gate_q;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end

      S_GATE: begin
        // A zero gate length wraps the down-counter and yields 2^GATE_W cycles.
        timer_d = timer_q - 1'b1;
        cnt_d   = edges_total;
        sat_d   = sat_total;
        if (win_end) begin
          count_d = edges_total;
          ovf_d   = sat_total;
          stb_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          sat_d   = 1'b0;
          timer_d = gate_q;
          if (!continuous_i) begin
            state_d = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      gate_q  <= '0;
      arm_q   <= '0;
      timer_q <= '0;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      arm_q   <= arm_d;
      timer_q <= timer_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      stb_q   <= stb_d;
    end
  end

  assign busy_o       = (state_q == S_ARM) || (state_q == S_GATE);
  assign done_o       = done_q;
  assign result_stb_o = stb_q;
  assign count_o      = count_q;
  assign overflow_o   = ovf_q;
  assign sout_o       = count_q[CNT_W-1];

endmodule

// File: tb/tb_ro_gate_counter.sv
// Bench for ro_gate_counter: three instances (default, 4-bit counter, 8-bit
// gate) driven from a vector table, with expected results held in a queue.
module tb_ro_gate_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  osc_in = '0;
  logic [1:0]  chan_sel;
  logic [11:0] gate_len;
  logic        continuous;
  logic        shift0;
  logic        tie0;
  logic [2:0]  start;
  logic [2:0]  busy, done, stb, ovf, sout;
  logic [15:0] cnt0, cnt2;
  logic [3:0]  cnt1;

  assign tie0 = 1'b0;

  always #5 clk = ~clk;

  ro_gate_counter u0 (
    .clk_i(clk), .rst_i(rst), .osc_in_i(osc_in), .chan_sel_i(chan_sel),
    .gate_len_i(gate_len), .start_i(start[0]), .continuous_i(continuous),
    .shift_i(shift0), .busy_o(busy[0]), .done_o(done[0]), .result_stb_o(stb[0]),
    .count_o(cnt0), .overflow_o(ovf[0]), .sout_o(sout[0])
  );

  ro_gate_counter #(.CNT_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .osc_in_i(osc_in), .chan_sel_i(chan_sel),
    .gate_len_i(gate_len), .start_i(start[1]), .continuous_i(tie0),
    .shift_i(tie0), .busy_o(busy[1]), .done_o(done[1]), .result_stb_o(stb[1]),
    .count_o(cnt1), .overflow_o(ovf[1]), .sout_o(sout[1])
  );

  ro_gate_counter #(.GATE_W(8)) u2 (
    .clk_i(clk), .rst_i(rst), .osc_in_i(osc_in), .chan_sel_i(chan_sel),
    .gate_len_i(gate_len[7:0]), .start_i(start[2]), .continuous_i(tie0),
    .shift_i(tie0), .busy_o(busy[2]), .done_o(done[2]), .result_stb_o(stb[2]),
    .count_o(cnt2), .overflow_o(ovf[2]), .sout_o(sout[2])
  );

  // Selected channel toggles every osc_half cycles; the others every 7.
  int tcyc = 0;
  int osc_half = 0;
  int osc_chan = 0;
  always @(negedge clk) begin
    tcyc = tcyc + 1;
    for (int c = 0; c < 4; c++) begin
      if (c == osc_chan)
        osc_in[c] = (osc_half > 0) && (((tcyc / osc_half) % 2) == 1);
      else
        osc_in[c] = ((tcyc / 7) % 2) == 1;
    end
  end

  typedef struct {
    int inst; int chan; int gate; int half; int exp_cnt; bit exp_ovf;
  } vec_t;

  typedef struct {
    int cnt; bit ovf; int lat;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int cnt_of(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Waits for result_stb on an instance; lat counts negedges since the edge
  // that sampled start (that edge's follow-up negedge is lat 1).
  task automatic wait_stb(input int inst, input int lat0, input int limit, input bit poke,
                          output int lat, output bit got);
    lat = lat0;
    got = 1'b0;
    while (!got && lat < limit) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start[inst] = 1'b0;
      if (poke && lat == 20) start[inst] = 1'b1;
      if (poke && lat == 21) start[inst] = 1'b0;
      if (stb[inst]) got = 1'b1;
    end
  endtask

  task automatic check_result(input int inst, input string tag, input int lat, input bit got);
    exp_t e;
    if (!got) begin
      chk({tag, "_stb_timeout"}, 0, 1);
      sb.delete();
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected_stb"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_count"}, cnt_of(inst), e.cnt);
      chk({tag, "_overflow"}, int'(ovf[inst]), int'(e.ovf));
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_done"}, int'(done[inst]), 1);
      $display("[TB] %s inst%0d count=%0d ovf=%0d lat=%0d", tag, inst, cnt_of(inst), ovf[inst], lat);
    end
  endtask

  task automatic run_vec(input int v);
    vec_t x;
    exp_t e;
    int   n, lat;
    bit   got;
    string tag;
    x = vecs[v];
    tag = $sformatf("vec%0d", v);
    osc_chan = x.chan;
    osc_half = x.half;
    chan_sel = 2'(x.chan);
    gate_len = 12'(x.gate);
    repeat (3) @(negedge clk);
    n = (x.gate == 0) ? ((x.inst == 2) ? 256 : 4096) : x.gate;
    e.cnt = x.exp_cnt;
    e.ovf = x.exp_ovf;
    e.lat = 3 + n + 1;
    sb.push_back(e);
    start[x.inst] = 1'b1;
    @(negedge clk);
    start[x.inst] = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy[x.inst]), 1);
    chk({tag, "_done_cleared"}, int'(done[x.inst]), 0);
    wait_stb(x.inst, 1, 6000, 1'b1, lat, got);
    check_result(x.inst, tag, lat, got);
    if (got) chk({tag, "_idle_after"}, int'(busy[x.inst]), 0);
  endtask

  initial begin
    int         lat;
    bit         got;
    int         extra;
    logic [15:0] bits;
    exp_t       e;

    vecs[0] = '{0, 2, 100,  5, 10,  1'b0};
    vecs[1] = '{0, 1, 64,   4, 8,   1'b0};
    vecs[2] = '{0, 0, 30,   3, 5,   1'b0};
    vecs[3] = '{0, 3, 120,  0, 0,   1'b0};
    vecs[4] = '{1, 3, 200,  2, 15,  1'b1};
    vecs[5] = '{1, 0, 40,   4, 5,   1'b0};
    vecs[6] = '{2, 2, 0,    4, 32,  1'b0};
    vecs[7] = '{0, 1, 3960, 3, 660, 1'b0};

    rst = 1'b1;
    start = '0;
    chan_sel = '0;
    gate_len = '0;
    continuous = 1'b0;
    shift0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_stb", int'(stb[0]), 0);
    chk("reset_count", int'(cnt0), 0);
    chk("reset_ovf", int'(ovf[0]), 0);
    chk("reset_sout", int'(sout[0]), 0);
    chk("reset_count_u1", int'(cnt1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(v);

    // Continuous mode: three back-to-back windows, then drop back to DONE.
    osc_chan = 2; osc_half = 5; chan_sel = 2'd2; gate_len = 12'd50;
    continuous = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e.cnt = 5; e.ovf = 1'b0; e.lat = (k == 0) ? 54 : 50;
      sb.push_back(e);
    end
    start[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_stb(0, 0, 300, 1'b0, lat, got);
      check_result(0, $sformatf("cont%0d", k), lat, got);
      if (k == 0) chk("cont_busy_between", int'(busy[0]), 1);
      if (k == 1) continuous = 1'b0;
    end
    start[0] = 1'b0;
    chk("cont_stop_idle", int'(busy[0]), 0);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (stb[0]) extra++;
    end
    chk("cont_no_extra_stb", extra, 0);

    // Serial readout of a measured 660 (0x0294), MSB first.
    run_vec(7);
    bits[15] = sout[0];
    shift0 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) bits[15-k] = sout[0];
    end
    shift0 = 1'b0;
    $display("[TB] shift sout=%b count_after=%0d", bits, cnt0);
    chk("shift_sout_seq", int'(bits), 16'h0294);
    chk("shift_count_zero", int'(cnt0), 0);

    // Start and shift together in DONE: start wins; shift in GATE ignored.
    run_vec(0);
    e.cnt = 10; e.ovf = 1'b0; e.lat = 104;
    sb.push_back(e);
    start[0] = 1'b1;
    shift0 = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    shift0 = 1'b0;
    chk("start_shift_count_kept", int'(cnt0), 10);
    chk("start_shift_busy", int'(busy[0]), 1);
    repeat (10) @(negedge clk);
    shift0 = 1'b1;
    @(negedge clk);
    shift0 = 1'b0;
    chk("shift_busy_ignored", int'(cnt0), 10);
    wait_stb(0, 12, 6000, 1'b0, lat, got);
    check_result(0, "start_shift", lat, got);

    // Asynchronous reset in the middle of a window.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", int'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy[0]), 0);
    chk("async_rst_count", int'(cnt0), 0);
    chk("async_rst_done", int'(done[0]), 0);
    chk("async_rst_sout", int'(sout[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
